// File: rtl/johnson_phase_tracker.sv
// Johnson counter phase tracker: decodes sampled counter words into a phase index,
// checks sequence legality, and maintains lock state with saturating error count.
module johnson_phase_tracker #(
   parameter int unsigned N          = 4,
   parameter int unsigned LOCK_COUNT = 3,
   parameter int unsigned ERR_W      = 8,
   localparam int unsigned PW        = $clog2(2 * N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [0:N-1]     jc_in,
   input  logic             jc_valid,
   output logic [PW-1:0]    phase,
   output logic [2*N-1:0]   phase_onehot,
   output logic             locked,
   output logic             wrap,
   output logic             err_illegal,
   output logic             err_skip,
   output logic [ERR_W-1:0] err_count
);

   localparam int unsigned P2 = 2 * N;
   localparam int unsigned AW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     phase_q, phase_d;
   logic [AW-1:0]     acq_q, acq_d;
   logic [P2-1:0]     onehot_q, onehot_d;
   logic              wrap_q, wrap_d;
   logic              ill_q, ill_d;
   logic              skip_q, skip_d;
   logic [ERR_W-1:0]  cnt_q, cnt_d;

   logic [PW-1:0]     ones;
   logic [PW-1:0]     dec_phase;
   logic [0:N-1]      pattern;
   logic              legal;
   logic [PW-1:0]     seq_phase;
   logic              in_seq;
   int unsigned       dp;

   // Phase follows from the popcount; bit 0 tells rising half from falling half.
   always_comb begin
      ones = '0;
      for (int unsigned i = 0; i < N; i++) begin
         ones = ones + PW'(jc_in[i]);
      end
      if (jc_in[0] || (ones == '0)) begin
         dec_phase = ones;
      end else begin
         dec_phase = PW'(P2) - ones;
      end
      dp = int'(dec_phase);
      for (int unsigned i = 0; i < N; i++) begin
         pattern[i] = (dp <= N) ? (i < dp) : (i >= dp - N);
      end
      legal = (pattern == jc_in);
   end

   assign seq_phase = (phase_q == PW'(P2 - 1)) ? '0 : phase_q + PW'(1);
   assign in_seq    = (dec_phase == seq_phase);

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      acq_d    = acq_q;
      wrap_d   = 1'b0;
      ill_d    = 1'b0;
      skip_d   = 1'b0;
      cnt_d    = cnt_q;
      onehot_d = '0;
      if (jc_valid) begin
         if (!legal) begin
            ill_d   = 1'b1;
            state_d = ST_UNLOCKED;
         end else begin
            phase_d = dec_phase;
            case (state_q)
               ST_UNLOCKED: begin
                  acq_d   = '0;
                  state_d = ST_ACQUIRE;
               end
               ST_ACQUIRE: begin
                  if (in_seq) begin
                     if (acq_q + AW'(1) == AW'(LOCK_COUNT)) begin
                        acq_d   = '0;
                        state_d = ST_LOCKED;
                     end else begin
                        acq_d = acq_q + AW'(1);
                     end
                  end else begin
                     acq_d = '0;
                  end
               end
               ST_LOCKED: begin
                  if (in_seq) begin
                     wrap_d = (phase_q == PW'(P2 - 1));
                  end else begin
                     skip_d  = 1'b1;
                     acq_d   = '0;
                     state_d = ST_ACQUIRE;
                  end
               end
               default: begin
                  state_d = ST_UNLOCKED;
               end
            endcase
         end
      end
      if ((ill_d || skip_d) && (cnt_q != '1)) begin
         cnt_d = cnt_q + ERR_W'(1);
      end
      if (state_d == ST_LOCKED) begin
         onehot_d[phase_d] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_UNLOCKED;
         phase_q  <= '0;
         acq_q    <= '0;
         onehot_q <= '0;
         wrap_q   <= 1'b0;
         ill_q    <= 1'b0;
         skip_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         acq_q    <= acq_d;
         onehot_q <= onehot_d;
         wrap_q   <= wrap_d;
         ill_q    <= ill_d;
         skip_q   <= skip_d;
         cnt_q    <= cnt_d;
      end
   end

   assign phase        = phase_q;
   assign phase_onehot = onehot_q;
   assign locked       = (state_q == ST_LOCKED);
   assign wrap         = wrap_q;
   assign err_illegal  = ill_q;
   assign err_skip     = skip_q;
   assign err_count    = cnt_q;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Randomized bench for johnson_phase_tracker against a table-driven reference model;
// a second instance with a 3-bit error counter exercises saturation.
module tb_johnson_phase_tracker;

   localparam int N  = 4;
   localparam int P2 = 2 * N;
   localparam int LC = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [0:N-1] jc_in;
   logic         jc_valid;

   logic [2:0]   phase, phase_s;
   logic [7:0]   onehot, onehot_s;
   logic         locked, locked_s, wrap, wrap_s;
   logic         ill, ill_s, skip, skip_s;
   logic [7:0]   cnt;
   logic [2:0]   cnt_s;

   johnson_phase_tracker #(.N(N), .LOCK_COUNT(LC), .ERR_W(8)) dut (
      .clk(clk), .rst(rst), .jc_in(jc_in), .jc_valid(jc_valid),
      .phase(phase), .phase_onehot(onehot), .locked(locked), .wrap(wrap),
      .err_illegal(ill), .err_skip(skip), .err_count(cnt)
   );

   johnson_phase_tracker #(.N(N), .LOCK_COUNT(LC), .ERR_W(3)) dut_sat (
      .clk(clk), .rst(rst), .jc_in(jc_in), .jc_valid(jc_valid),
      .phase(phase_s), .phase_onehot(onehot_s), .locked(locked_s), .wrap(wrap_s),
      .err_illegal(ill_s), .err_skip(skip_s), .err_count(cnt_s)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Reference model: legal words come from stepping a Johnson shift register.
   logic [0:N-1] jtab [P2];
   int m_st;   // 0 unlocked, 1 acquiring, 2 locked
   int m_ph, m_acq, m_cnt;
   bit m_wrap, m_ill, m_skip;

   function automatic int decode(input logic [0:N-1] w);
      for (int p = 0; p < P2; p++) if (jtab[p] == w) return p;
      return -1;
   endfunction

   task automatic model_step(input bit r, input bit v, input logic [0:N-1] w);
      int p;
      m_wrap = 0; m_ill = 0; m_skip = 0;
      if (r) begin
         m_st = 0; m_ph = 0; m_acq = 0; m_cnt = 0;
         return;
      end
      if (!v) return;
      p = decode(w);
      if (p < 0) begin
         m_ill = 1;
         m_st  = 0;
      end else if (m_st == 0) begin
         m_ph = p; m_acq = 0; m_st = 1;
      end else if (m_st == 1) begin
         if (p == (m_ph + 1) % P2) begin
            m_ph = p; m_acq++;
            if (m_acq == LC) m_st = 2;
         end else begin
            m_ph = p; m_acq = 0;
         end
      end else begin
         if (p == (m_ph + 1) % P2) begin
            m_wrap = (m_ph == P2 - 1);
            m_ph = p;
         end else begin
            m_skip = 1; m_ph = p; m_acq = 0; m_st = 1;
         end
      end
      if (m_ill || m_skip) m_cnt++;
   endtask

   task automatic compare_all();
      int exp_oh;
      exp_oh = (m_st == 2) ? (1 << m_ph) : 0;
      check("phase", phase, m_ph);
      check("onehot", onehot, exp_oh);
      check("locked", locked, (m_st == 2));
      check("wrap", wrap, m_wrap);
      check("err_illegal", ill, m_ill);
      check("err_skip", skip, m_skip);
      check("err_count", cnt, (m_cnt > 255) ? 255 : m_cnt);
      check("sat_count", cnt_s, (m_cnt > 7) ? 7 : m_cnt);
      check("sat_locked", locked_s, (m_st == 2));
      check("sat_phase", phase_s, m_ph);
   endtask

   task automatic cycle(input bit r, input bit v, input logic [0:N-1] w);
      rst = r; jc_valid = v; jc_in = w;
      @(posedge clk);
      model_step(r, v, w);
      #1;
      compare_all();
   endtask

   task automatic feed(input logic [0:N-1] w);
      cycle(1'b0, 1'b1, w);
   endtask

   initial begin
      logic [0:N-1] w;
      logic [0:N-1] acq_seq [4];
      logic [0:N-1] wrap_seq [6];
      int r;

      w = '0;
      for (int p = 0; p < P2; p++) begin
         jtab[p] = w;
         w = {~w[N-1], w[0:N-2]};
      end
      m_st = 0; m_ph = 0; m_acq = 0; m_cnt = 0;
      rst = 1'b1; jc_valid = 1'b0; jc_in = '0;

      cycle(1'b1, 1'b0, 4'b0000);
      cycle(1'b1, 1'b1, 4'b1010);
      check("rst_locked", locked, 0);
      check("rst_count", cnt, 0);

      // Acquire from anchor p7
      acq_seq = '{4'b0001, 4'b0000, 4'b1000, 4'b1100};
      for (int i = 0; i < 4; i++) feed(acq_seq[i]);
      check("acq_locked", locked, 1);
      check("acq_phase", phase, 2);
      check("acq_onehot", onehot, 8'b0000_0100);

      // Continue through the wrap
      wrap_seq = '{4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
      for (int i = 0; i < 6; i++) begin
         feed(wrap_seq[i]);
         check("wrap_pulse", wrap, (i == 5));
      end
      check("wrap_phase", phase, 0);

      // Illegal while locked at p3
      feed(4'b1000); feed(4'b1100); feed(4'b1110);
      check("pre_ill_locked", locked, 1);
      feed(4'b1010);
      check("ill_pulse", ill, 1);
      check("ill_phase", phase, 3);
      check("ill_onehot", onehot, 0);
      check("ill_count", cnt, 1);
      feed(4'b1111);

      // Skip while locked at p3
      cycle(1'b1, 1'b0, 4'b0000);
      feed(4'b0000); feed(4'b1000); feed(4'b1100); feed(4'b1110);
      check("pre_skip_locked", locked, 1);
      feed(4'b0111);
      check("skip_pulse", skip, 1);
      check("skip_count", cnt, 1);
      feed(4'b0011); feed(4'b0001); feed(4'b0000);
      check("relock", locked, 1);
      check("relock_phase", phase, 0);

      // Gaps, then reset while locked
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 4'b1010);
      check("gap_locked", locked, 1);
      cycle(1'b1, 1'b1, 4'b1000);
      check("rst_mid_locked", locked, 0);
      check("rst_mid_phase", phase, 0);

      // Saturation on the 3-bit counter
      for (int i = 0; i < 9; i++) begin
         feed(4'b1010);
         check("sat_pulse", ill_s, 1);
      end
      check("sat_final", cnt_s, 7);
      check("wide_final", cnt, 9);

      // Randomized traffic, biased toward in-sequence words
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 1) begin
            cycle(1'b1, $urandom_range(0, 1), N'($urandom));
         end else if (r < 25) begin
            cycle(1'b0, 1'b0, N'($urandom));
         end else if (r < 80) begin
            feed(jtab[(m_ph + 1) % P2]);
         end else if (r < 90) begin
            feed(jtab[$urandom_range(0, P2 - 1)]);
         end else begin
            feed(N'($urandom));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/johnson_phase_tracker.md
Name: johnson_phase_tracker

Overview:
Downstream consumer of the N-bit Johnson counter. Samples the counter word on each advance strobe, decodes it into a binary phase index and a one-hot phase strobe, checks that successive words follow the legal Johnson sequence, and keeps a lock state machine with error flags and a saturating error counter. Its outputs drive phase-sequenced logic such as multi-phase enables and the clock-divider taps.

Parameters:
N, 4, Johnson counter width; legal phases 0..2N-1; N >= 2
LOCK_COUNT, 3, consecutive in-sequence samples after the anchor needed to enter LOCKED; >= 1
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
jc_in  input  [0:N-1]  Johnson counter word; bit 0 is the bit that takes the inverted feedback
jc_valid  input  1  high for one cycle each time the counter has advanced; jc_in is sampled only when this is high
phase  output  PW = clog2(2N)  binary index of the last legal sample
phase_onehot  output  2N  bit[phase] set while locked; all zero otherwise
locked  output  1  high in LOCKED state
wrap  output  1  one-cycle pulse on a locked transition from phase 2N-1 to phase 0
err_illegal  output  1  one-cycle pulse when a sampled word is not a legal Johnson state
err_skip  output  1  one-cycle pulse when a legal word is out of sequence while LOCKED
err_count  output  ERR_W  count of err_illegal plus err_skip pulses, saturates at all-ones

Behaviour:
- Legal words: phase p for 0 <= p <= N has bits 0..p-1 = 1 and the rest 0. Phase p for N < p < 2N has bits 0..p-N-1 = 0 and the rest 1. With N=4: p0=0000, p1=1000, p2=1100, p3=1110, p4=1111, p5=0111, p6=0011, p7=0001. Every other word is illegal.
- Decode is combinational from jc_in. All outputs are registered and update at the clk edge where jc_valid=1, so they are visible in the following cycle.
- jc_valid=0: state, phase, phase_onehot, locked and err_count hold; wrap, err_illegal and err_skip are 0.
- In-sequence means new phase = (previous phase + 1) mod 2N. A repeated phase counts as out of sequence.
- Reset: state UNLOCKED; phase=0, phase_onehot=0, locked=0, wrap=0, err_illegal=0, err_skip=0, err_count=0, acquire counter=0. Reset overrides jc_valid in the same cycle. Reset mid-lock drops lock immediately.
- UNLOCKED:
  - Legal sample: store its phase as anchor, acquire counter=0, go to ACQUIRE.
  - Illegal sample: err_illegal pulse, stay UNLOCKED.
- ACQUIRE:
  - In-sequence legal sample: update phase, increment acquire counter. When the counter reaches LOCK_COUNT, go to LOCKED at that edge; locked=1 and phase_onehot becomes valid at the same edge.
  - Out-of-sequence legal sample: re-anchor at the new phase, counter=0, stay ACQUIRE. No error pulse.
  - Illegal sample: err_illegal pulse, go to UNLOCKED.
- LOCKED:
  - In-sequence sample: update phase and phase_onehot. wrap=1 if the transition is 2N-1 -> 0.
  - Out-of-sequence legal sample: err_skip pulse, re-anchor at that phase, go to ACQUIRE. locked=0, phase_onehot=0.
  - Illegal sample: err_illegal pulse, go to UNLOCKED. locked=0, phase_onehot=0. phase keeps the last legal value.
- err_count increments by 1 on each cycle where err_illegal or err_skip is 1 (the two are never both 1). It holds at 2^ERR_W-1 and clears only on rst.
- phase_onehot is never non-zero while locked=0.

Test Plan:
- Acquire (N=4, LOCK_COUNT=3): reset, then feed valid 0001,0000,1000,1100 -> anchor p7. locked=1 after the 4th edge, phase=2, phase_onehot=8'b0000_0100, no error pulses.
- Wrap: from locked, continue 1110,1111,0111,0011,0001,0000 -> phase steps 3..7 then 0; wrap=1 for exactly the cycle after the 0000 sample, 0 otherwise.
- Illegal word: locked at p3, feed 1010 -> err_illegal=1 for one cycle, err_count=1, locked=0, phase_onehot=0, phase stays 3. The next legal word re-enters ACQUIRE.
- Skip: locked at p3, feed 0111 (p5) -> err_skip=1, err_count increments, state ACQUIRE anchored at 5. Then 0011,0001,0000 -> relocked with phase=0.
- Gaps and reset: with jc_valid=0 for 5 cycles, all outputs hold and pulses stay 0. Assert rst while locked with jc_valid=1 -> next cycle locked=0, phase=0, err_count=0.
- Saturation (ERR_W=3): feed 9 illegal valid words -> err_count reaches 7 and holds; err_illegal still pulses on each word.
